// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// Inhibits the bus, issues a request-to-send and clocks out one command byte
// (8 data bits, odd parity, stop) on device-generated clock edges. It then
// checks the device ACK and waits for both lines to go idle.
// Optional build macro PS2_TX_TIMEOUT_EN adds a watchdog. The watchdog aborts
// the frame when the device stops clocking for TIMEOUT_CYCLES cycles.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       err,
  output logic       busy
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES + 1) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_WAIT_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t           state;
  logic [9:0]       frame;
  logic [3:0]       bit_cnt;
  logic [INH_W-1:0] inh_cnt;

  logic clk_s1, clk_s2, clk_prev;
  logic data_s1, data_s2;
  logic ps2_fall;
  logic waiting;
  logic timeout_hit;

  // Two-flop synchronizers for both bus lines plus a delayed clock copy for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data_in;
      data_s2  <= data_s1;
    end
  end

  assign ps2_fall = clk_prev & ~clk_s2;
  assign waiting  = (state == S_SEND) || (state == S_WAIT_ACK) || (state == S_WAIT_IDLE);

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;

  // Watchdog counts cycles since the last device clock edge while the device owns the clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (!waiting || ps2_fall) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_LAST) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout_hit = waiting && !ps2_fall && (to_cnt == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // Frame sequencer: inhibit, request, shift bits on device falling edges, then check ACK and idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      frame       <= '0;
      bit_cnt     <= '0;
      inh_cnt     <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (timeout_hit) begin
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        err         <= 1'b1;
        tx_ready    <= 1'b1;
        busy        <= 1'b0;
        state       <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (tx_valid && tx_ready) begin
              frame       <= {1'b1, ~^tx_data, tx_data};
              inh_cnt     <= '0;
              bit_cnt     <= '0;
              ps2_clk_oe  <= 1'b1;
              ps2_data_oe <= 1'b0;
              tx_ready    <= 1'b0;
              busy        <= 1'b1;
              state       <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            if (inh_cnt == INH_LAST) begin
              ps2_data_oe <= 1'b1;
              state       <= S_REQ;
            end else begin
              inh_cnt <= inh_cnt + 1'b1;
            end
          end
          S_REQ: begin
            ps2_clk_oe <= 1'b0;
            bit_cnt    <= '0;
            state      <= S_SEND;
          end
          S_SEND: begin
            if (ps2_fall) begin
              ps2_data_oe <= ~frame[0];
              frame       <= {1'b0, frame[9:1]};
              bit_cnt     <= bit_cnt + 1'b1;
              if (bit_cnt == 4'd9) begin
                state <= S_WAIT_ACK;
              end
            end
          end
          S_WAIT_ACK: begin
            if (ps2_fall) begin
              if (!data_s2) begin
                state <= S_WAIT_IDLE;
              end else begin
                err      <= 1'b1;
                tx_ready <= 1'b1;
                busy     <= 1'b0;
                state    <= S_IDLE;
              end
            end
          end
          S_WAIT_IDLE: begin
            if (clk_s2 && data_s2) begin
              done     <= 1'b1;
              tx_ready <= 1'b1;
              busy     <= 1'b0;
              state    <= S_IDLE;
            end
          end
          default: begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized bench for ps2_host_tx with a behavioural PS/2 device.
// Build with PS2_TX_TIMEOUT_EN defined to expect the watchdog abort on a stalled device.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH  = 16;
  localparam int TOC  = 200;
  localparam int HALF = 8;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       done;
  logic       err;
  logic       busy;
  logic       dev_clk;
  logic       dev_data;
  logic       clk_line;
  logic       data_line;

  int checks = 0;
  int passes = 0;
  int done_seen = 0;
  int err_seen = 0;
  int both_seen = 0;
  int inh_seen = 0;
  bit hold_mode = 0;

  // Open-drain bus: a line is low when either side pulls it low
  assign clk_line  = dev_clk & ~ps2_clk_oe;
  assign data_line = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TOC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_in (clk_line),
    .ps2_data_in(data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .done       (done),
    .err        (err),
    .busy       (busy)
  );

  // 100 MHz system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse and inhibit-phase counters sampled on the falling system clock edge
  always @(negedge clk) begin
    if (done) done_seen++;
    if (err) err_seen++;
    if (done && err) both_seen++;
    if (ps2_clk_oe && !ps2_data_oe) inh_seen++;
  end

  // Hard stop in case a bounded wait is itself broken
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (hold_mode) tx_data = 8'($urandom);
    end
  endtask

  // One host frame against the device model; cut>0 stops the device right after that falling edge
  task automatic applyStimulus(input logic [7:0] d, input bit ack, input int cut);
    int base_done, base_err, base_both, base_inh, n, ones;
    logic [9:0] seen;
    logic [9:0] want;
    ones = 0;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    want = {1'b1, (ones % 2 == 0), d};
    seen = '0;
    n = 0;
    while (!tx_ready && n < 100) begin tick(1); n++; end
    checkOutput("ready_before_req", 32'(tx_ready), 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    base_done = done_seen;
    base_err  = err_seen;
    base_both = both_seen;
    base_inh  = inh_seen;
    if (hold_mode) tx_data = 8'($urandom);
    else tx_valid = 1'b0;
    n = 0;
    while (!(busy && !ps2_clk_oe && ps2_data_oe) && n < INH + 20) begin tick(1); n++; end
    checkOutput("start_bit", 32'({ps2_clk_oe, ps2_data_oe}), 32'b01);
    checkOutput("inhibit_len", 32'(inh_seen - base_inh), 32'(INH));
    tick(4);
    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b0;
      tick(4);
      if (k == cut) return;
      tick(HALF - 4);
      dev_clk = 1'b1;
      tick(HALF);
      seen[k-1] = data_line;
    end
    checkOutput("frame_bits", 32'(seen), 32'(want));
    dev_data = ack ? 1'b0 : 1'b1;
    tick(4);
    dev_clk = 1'b0;
    tick(HALF);
    dev_clk = 1'b1;
    tick(2);
    dev_data = 1'b1;
    n = 0;
    while (busy && n < 100) begin tick(1); n++; end
    tx_valid = 1'b0;
    checkOutput("busy_drop", 32'(busy), 32'd0);
    tick(2);
    checkOutput("done_count", 32'(done_seen - base_done), ack ? 32'd1 : 32'd0);
    checkOutput("err_count", 32'(err_seen - base_err), ack ? 32'd0 : 32'd1);
    checkOutput("done_err_overlap", 32'(both_seen - base_both), 32'd0);
    checkOutput("ready_after", 32'(tx_ready), 32'd1);
    checkOutput("lines_released", 32'({ps2_clk_oe, ps2_data_oe, busy}), 32'd0);
  endtask

  initial begin
    int base_done, base_err;
    logic [7:0] rd;
    rst      = 1'b0;
    tx_data  = '0;
    tx_valid = 1'b0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_state", 32'({tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, err}), 32'b100000);
    rst = 1'b0;

    applyStimulus(8'hF4, 1'b1, 0);
    applyStimulus(8'hFF, 1'b1, 0);
    applyStimulus(8'h00, 1'b1, 0);
    applyStimulus(8'h5A, 1'b0, 0);
    for (int r = 0; r < 6; r++) begin
      rd = 8'($urandom);
      applyStimulus(rd, $urandom_range(0, 3) != 0, 0);
    end

    hold_mode = 1'b1;
    applyStimulus(8'h3C, 1'b1, 0);
    hold_mode = 1'b0;

    // Reset while the device is mid-frame at falling edge 6
    base_done = done_seen;
    base_err  = err_seen;
    applyStimulus(8'hF4, 1'b1, 6);
    #3 rst = 1'b1;
    #1;
    checkOutput("rst_lines", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    checkOutput("rst_ready", 32'({tx_ready, busy}), 32'b10);
    dev_clk = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(20);
    checkOutput("rst_no_pulse", 32'((done_seen - base_done) + (err_seen - base_err)), 32'd0);
    applyStimulus(8'hF4, 1'b1, 0);

    // Device stops clocking after falling edge 4
    base_err = err_seen;
    applyStimulus(8'hA5, 1'b1, 4);
    dev_clk = 1'b1;
    tick(TOC + 50);
`ifdef PS2_TX_TIMEOUT_EN
    checkOutput("timeout_err", 32'(err_seen - base_err), 32'd1);
    checkOutput("timeout_lines", 32'({ps2_clk_oe, ps2_data_oe, busy}), 32'd0);
`else
    checkOutput("stall_busy", 32'(busy), 32'd1);
    checkOutput("stall_no_err", 32'(err_seen - base_err), 32'd0);
`endif
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    applyStimulus(8'h81, 1'b1, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
